vga_stream_packer: RTL
======================

Name: vga_stream_packer

Overview:
- Sits between the camera/image-processing outputs and the SDRAM write FIFO of the VGA path.
- Selects one of four pixel streams: RGB, binarized, eroded or dilated.
- Packs the selected pixel into a 16-bit FIFO word and emits it with a write strobe.
- Tracks pixel position inside the frame so that source switching happens only on frame boundaries. This avoids torn frames in the SDRAM buffer.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- COMP_W, 12, width of each raw RGB component.
- SYNC_GAP, 64, consecutive cycles with no valid on the selected source that are taken as vertical blanking.

Ports:
- clk  in  1  pixel clock (camera pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- mode_sel  in  2  requested source: 0 RGB, 1 binarized, 2 eroded, 3 dilated.
- restart  in  1  one-cycle pulse; forces realignment (same meaning as FIFO LOAD).
- rgb_red, rgb_green, rgb_blue  in  COMP_W each  RGB components.
- rgb_valid  in  1  RGB pixel valid.
- bin_data, ero_data, dil_data  in  8 each  binary images (0x00/0xFF).
- bin_valid, ero_valid, dil_valid  in  1 each  matching valids.
- fifo_wrdata  out  16  packed pixel.
- fifo_wren  out  1  FIFO write strobe.
- rgb_mode  out  1  1 when the currently committed source is RGB (drives VGA unpacking).
- column  out  clog2(IMG_WIDTH)  column of the last written pixel.
- row  out  clog2(IMG_HEIGHT)  row of the last written pixel.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- frame_count  out  16  completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset values:
  - fifo_wrdata=0, fifo_wren=0, rgb_mode=1, column=0, row=0, frame_done=0, frame_count=0.
  - Committed mode=RGB.
  - state=ALIGN, gap counter=0.
- Packing:
  - RGB: {1'b0, R[COMP_W-1 -: 5], G[COMP_W-1 -: 5], B[COMP_W-1 -: 5]}.
  - Binary sources: {8'h00, data}.
- Latency: a valid selected input in cycle N gives fifo_wren=1 and data in cycle N+1. There is no backpressure.
- Only the committed source's valid/data are observed. Other sources are ignored.
- States:
  - ALIGN:
    - fifo_wren forced 0.
    - Gap counter counts cycles with selected valid=0 and saturates at SYNC_GAP. Any valid resets it to 0.
    - The committed mode is loaded from mode_sel every cycle.
    - When gap==SYNC_GAP, go to ARMED.
  - ARMED:
    - Waiting for the first pixel; fifo_wren stays 0 until the valid arrives.
    - On the first selected valid: write it as pixel (0,0) and go to STREAM.
  - STREAM:
    - Each valid writes a pixel and advances column.
    - When column==IMG_WIDTH-1 it wraps to 0 and row increments.
    - On the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1):
      - frame_done=1 in the same output cycle as that write.
      - frame_count increments.
      - row and column wrap to 0.
      - If mode_sel differs from the committed mode, go to ALIGN; otherwise stay in STREAM.
  - A mode_sel change mid-frame has no effect until the frame ends.
  - A gap ≥ SYNC_GAP in STREAM before the frame is complete means a short frame. Discard the partial count (no frame_done, frame_count unchanged) and go to ARMED.
- restart or reset has priority over everything, at any state:
  - restart: go to ALIGN, row/column=0, fifo_wren=0 next cycle. frame_count is kept; only reset clears it.
- rgb_mode mirrors the committed mode, registered. It changes only while fifo_wren=0.

Optional Feature:
- Macro: VGA_STREAM_TEST_PATTERN_EN.
- When defined, adds input test_en (1 bit).
- When test_en=1, the RGB path's data are replaced by 8 vertical colour bars, each IMG_WIDTH/8 columns wide. Bar colours in order: white 0x7FFF, yellow 0x7FE0, cyan 0x03FF, green 0x03E0, magenta 0x7C1F, red 0x7C00, blue 0x001F, black 0x0000.
- Timing and valids still come from rgb_valid. Binary modes are unaffected.
- When undefined, the port and logic are absent and behaviour is exactly as above.

Decomposition:
- Package vga_stream_pkg holds:
  - mode enum (MODE_RGB, MODE_BIN, MODE_ERO, MODE_DIL).
  - state enum (ALIGN, ARMED, STREAM).
  - RGB555 pack function.
  - colour-bar constants.
- One sub-module, frame_pos_counter:
  - Column/row counter with an advance input and a clear input.
  - Outputs last_pixel and the wrap flags.

Test Plan:
- Reset, mode 0, 70 idle cycles, then rgb_valid with R=G=B=0xFFF → fifo_wrdata=0x7FFF, fifo_wren one cycle after each valid, first write at column 0, row 0.
- Full 640×480 frame of bin_valid with mode 1 → exactly 307200 writes of 0x00xx, frame_done single pulse on the last write, frame_count=1.
- mode_sel changed 0→3 at pixel 1000 → the rest of the frame is still written from RGB with rgb_mode=1. After frame_done, fifo_wren stays 0 until a 64-cycle gap on dil_valid, then dilated data with rgb_mode=0.
- Frame truncated after 5000 pixels followed by a 64-cycle gap → no frame_done, frame_count unchanged, the next valid is written at (0,0).
- restart pulse mid-frame → fifo_wren=0 from the next cycle, state ALIGN, frame_count retained.
- With VGA_STREAM_TEST_PATTERN_EN and test_en=1 → column 0 gives 0x7FFF, column 80 gives 0x7FE0, column 639 gives 0x0000.

Source files
------------

// File: rtl/vga_stream_packer_pkg.sv
// ---------------------------------------------------------------------------
// vga_stream_pkg
// Shared types and helpers for the VGA stream packer:
//   - mode_t   : pixel source selection (RGB / binarized / eroded / dilated)
//   - state_t  : frame alignment state machine states
//   - pack_rgb555 : packs three 5-bit components into a 16-bit FIFO word
//   - BAR_*    : RGB555 colour-bar constants and bar_colour() lookup
// ---------------------------------------------------------------------------
package vga_stream_pkg;

   typedef enum logic [1:0] {
      MODE_RGB = 2'd0,
      MODE_BIN = 2'd1,
      MODE_ERO = 2'd2,
      MODE_DIL = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ALIGN  = 2'd0,
      ARMED  = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int NUM_BARS = 8;

   localparam logic [15:0] BAR_WHITE   = 16'h7FFF;
   localparam logic [15:0] BAR_YELLOW  = 16'h7FE0;
   localparam logic [15:0] BAR_CYAN    = 16'h03FF;
   localparam logic [15:0] BAR_GREEN   = 16'h03E0;
   localparam logic [15:0] BAR_MAGENTA = 16'h7C1F;
   localparam logic [15:0] BAR_RED     = 16'h7C00;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   // MSB is left zero so the VGA unpacker can treat the word as plain RGB555.
   function automatic logic [15:0] pack_rgb555(input logic [4:0] r,
                                               input logic [4:0] g,
                                               input logic [4:0] b);
      return {1'b0, r, g, b};
   endfunction

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] colour;
      case (idx)
         3'd0:    colour = BAR_WHITE;
         3'd1:    colour = BAR_YELLOW;
         3'd2:    colour = BAR_CYAN;
         3'd3:    colour = BAR_GREEN;
         3'd4:    colour = BAR_MAGENTA;
         3'd5:    colour = BAR_RED;
         3'd6:    colour = BAR_BLUE;
         default: colour = BAR_BLACK;
      endcase
      return colour;
   endfunction

endpackage

// File: rtl/vga_stream_packer_if.sv
// ---------------------------------------------------------------------------
// vga_stream_packer_if
// Pixel-source bundle (RGB + three binary images, each with a valid) and the
// SDRAM write-FIFO side (fifo_wrdata / fifo_wren).
//   master : the environment (drives pixel sources, observes FIFO writes)
//   slave  : the packer (consumes pixel sources, drives FIFO writes)
// ---------------------------------------------------------------------------
interface vga_stream_packer_if #(
   parameter int COMP_W = 12
) ();
   logic [COMP_W-1:0] rgb_red;
   logic [COMP_W-1:0] rgb_green;
   logic [COMP_W-1:0] rgb_blue;
   logic              rgb_valid;
   logic [7:0]        bin_data;
   logic              bin_valid;
   logic [7:0]        ero_data;
   logic              ero_valid;
   logic [7:0]        dil_data;
   logic              dil_valid;
   logic [15:0]       fifo_wrdata;
   logic              fifo_wren;

   modport master (
      output rgb_red, rgb_green, rgb_blue, rgb_valid,
      output bin_data, bin_valid, ero_data, ero_valid, dil_data, dil_valid,
      input  fifo_wrdata, fifo_wren
   );

   modport slave (
      input  rgb_red, rgb_green, rgb_blue, rgb_valid,
      input  bin_data, bin_valid, ero_data, ero_valid, dil_data, dil_valid,
      output fifo_wrdata, fifo_wren
   );
endinterface

// File: rtl/vga_stream_packer_frame_pos_counter.sv
// ---------------------------------------------------------------------------
// frame_pos_counter
// Column/row position of the next pixel to be written within a frame.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : return to (0,0); wins over advance
//   advance      : a pixel was written at the current position
//   column, row  : current (next-to-write) position
//   col_wrap     : current column is the last of the line
//   row_wrap     : current row is the last of the frame
//   last_pixel   : current position is the final pixel of the frame
// ---------------------------------------------------------------------------
module frame_pos_counter #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   localparam int COL_W = $clog2(IMG_WIDTH),
   localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   output logic [COL_W-1:0] column,
   output logic [ROW_W-1:0] row,
   output logic             col_wrap,
   output logic             row_wrap,
   output logic             last_pixel
);
   import vga_stream_pkg::*;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] column_reg;
   logic [ROW_W-1:0] row_reg;

   assign col_wrap   = (column_reg == COL_LAST);
   assign row_wrap   = (row_reg == ROW_LAST);
   assign last_pixel = col_wrap && row_wrap;
   assign column     = column_reg;
   assign row        = row_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         column_reg <= '0;
         row_reg    <= '0;
      end else if (advance) begin
         if (col_wrap) begin
            column_reg <= '0;
            row_reg    <= row_wrap ? '0 : row_reg + 1'b1;
         end else begin
            column_reg <= column_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_stream_packer.sv
// ---------------------------------------------------------------------------
// vga_stream_packer
// Selects one of four pixel streams (RGB, binarized, eroded, dilated), packs
// it into a 16-bit SDRAM write-FIFO word and tracks the frame position so a
// source switch only ever takes effect on a frame boundary.
//
// Optional feature macro: VGA_STREAM_TEST_PATTERN_EN
//   adds input test_en; when high the RGB data are replaced by 8 vertical
//   colour bars (timing still follows rgb_valid).
//
// Ports:
//   clk, reset   : pixel clock, synchronous active-high reset
//   mode_sel     : requested source (0 RGB, 1 bin, 2 ero, 3 dil)
//   restart      : one-cycle realignment pulse (frame_count kept)
//   test_en      : colour-bar enable (only with the macro above)
//   bus          : slave side of vga_stream_packer_if (sources in, FIFO out)
//   rgb_mode     : committed source is RGB
//   column, row  : position of the last written pixel
//   frame_done   : pulse with the write of the final pixel of a frame
//   frame_count  : completed frames (wraps)
// ---------------------------------------------------------------------------
module vga_stream_packer
   import vga_stream_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COMP_W     = 12,
   parameter int SYNC_GAP   = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [1:0]                    mode_sel,
   input  logic                          restart,
`ifdef VGA_STREAM_TEST_PATTERN_EN
   input  logic                          test_en,
`endif
   vga_stream_packer_if.slave            bus,
   output logic                          rgb_mode,
   output logic [$clog2(IMG_WIDTH)-1:0]  column,
   output logic [$clog2(IMG_HEIGHT)-1:0] row,
   output logic                          frame_done,
   output logic [15:0]                   frame_count
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int GAP_W = $clog2(SYNC_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SYNC_GAP);

   state_t            state_reg;
   mode_t             mode_reg;
   logic [GAP_W-1:0]  gap_reg;
   logic [GAP_W-1:0]  gap_next;
   logic [15:0]       fifo_wrdata_reg;
   logic              fifo_wren_reg;
   logic              rgb_mode_reg;
   logic [COL_W-1:0]  column_reg;
   logic [ROW_W-1:0]  row_reg;
   logic              frame_done_reg;
   logic [15:0]       frame_count_reg;

   logic [COL_W-1:0]  pos_col;
   logic [ROW_W-1:0]  pos_row;
   logic              col_wrap;
   logic              row_wrap;
   logic              last_pixel;

   logic [15:0]       rgb_word;
   logic              sel_valid;
   logic [15:0]       sel_word;
   logic              write_now;
   logic              short_frame;
   logic              cnt_clear;

   // -----------------------------------------------------------------------
   // RGB packing (optionally overridden by colour bars keyed on the column
   // the pixel is about to be written to)
   // -----------------------------------------------------------------------
`ifdef VGA_STREAM_TEST_PATTERN_EN
   localparam int BAR_W = (IMG_WIDTH / NUM_BARS > 0) ? IMG_WIDTH / NUM_BARS : 1;
   logic [2:0] bar_idx;
   assign bar_idx = 3'(int'(pos_col) / BAR_W);
   assign rgb_word = test_en ? bar_colour(bar_idx)
                             : pack_rgb555(bus.rgb_red[COMP_W-1 -: 5],
                                           bus.rgb_green[COMP_W-1 -: 5],
                                           bus.rgb_blue[COMP_W-1 -: 5]);
`else
   assign rgb_word = pack_rgb555(bus.rgb_red[COMP_W-1 -: 5],
                                 bus.rgb_green[COMP_W-1 -: 5],
                                 bus.rgb_blue[COMP_W-1 -: 5]);
`endif

   // Only the committed source is observed; the others are ignored.
   always_comb begin
      sel_valid = 1'b0;
      sel_word  = 16'h0000;
      case (mode_reg)
         MODE_RGB: begin
            sel_valid = bus.rgb_valid;
            sel_word  = rgb_word;
         end
         MODE_BIN: begin
            sel_valid = bus.bin_valid;
            sel_word  = {8'h00, bus.bin_data};
         end
         MODE_ERO: begin
            sel_valid = bus.ero_valid;
            sel_word  = {8'h00, bus.ero_data};
         end
         default: begin
            sel_valid = bus.dil_valid;
            sel_word  = {8'h00, bus.dil_data};
         end
      endcase
   end

   // Saturating count of consecutive idle cycles on the committed source.
   assign gap_next = sel_valid ? '0 :
                     (gap_reg == GAP_MAX) ? gap_reg : gap_reg + 1'b1;

   assign write_now   = (state_reg != ALIGN) && sel_valid && !restart;
   assign short_frame = (state_reg == STREAM) && !sel_valid && (gap_next == GAP_MAX);
   // Position is held at (0,0) while aligning so ARMED always writes (0,0).
   assign cnt_clear   = restart || (state_reg == ALIGN) || short_frame;

   frame_pos_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_pos (
      .clk        (clk),
      .reset      (reset),
      .clear      (cnt_clear),
      .advance    (write_now),
      .column     (pos_col),
      .row        (pos_row),
      .col_wrap   (col_wrap),
      .row_wrap   (row_wrap),
      .last_pixel (last_pixel)
   );

   // Line-level wrap flags are not needed at this level.
   logic unused_wrap;
   assign unused_wrap = col_wrap ^ row_wrap;

   // -----------------------------------------------------------------------
   // Alignment FSM with registered outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ALIGN;
         mode_reg        <= MODE_RGB;
         gap_reg         <= '0;
         fifo_wrdata_reg <= 16'h0000;
         fifo_wren_reg   <= 1'b0;
         rgb_mode_reg    <= 1'b1;
         column_reg      <= '0;
         row_reg         <= '0;
         frame_done_reg  <= 1'b0;
         frame_count_reg <= 16'h0000;
      end else if (restart) begin
         state_reg      <= ALIGN;
         gap_reg        <= '0;
         fifo_wren_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         column_reg     <= '0;
         row_reg        <= '0;
      end else begin
         fifo_wren_reg  <= write_now;
         frame_done_reg <= 1'b0;
         if (write_now) begin
            fifo_wrdata_reg <= sel_word;
            column_reg      <= pos_col;
            row_reg         <= pos_row;
         end

         case (state_reg)
            ALIGN: begin
               // Nothing is written here, so the mode may change freely.
               mode_reg     <= mode_t'(mode_sel);
               rgb_mode_reg <= (mode_t'(mode_sel) == MODE_RGB);
               gap_reg      <= gap_next;
               if (gap_next == GAP_MAX) begin
                  state_reg <= ARMED;
               end
            end
            ARMED: begin
               gap_reg <= gap_next;
               if (sel_valid) begin
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               gap_reg <= gap_next;
               if (sel_valid && last_pixel) begin
                  frame_done_reg  <= 1'b1;
                  frame_count_reg <= frame_count_reg + 16'd1;
                  if (mode_t'(mode_sel) != mode_reg) begin
                     state_reg <= ALIGN;
                     gap_reg   <= '0;
                  end
               end else if (short_frame) begin
                  // Partial frame is dropped; resync on the next pixel.
                  state_reg <= ARMED;
               end
            end
            default: begin
               state_reg <= ALIGN;
               gap_reg   <= '0;
            end
         endcase
      end
   end

   assign bus.fifo_wrdata = fifo_wrdata_reg;
   assign bus.fifo_wren   = fifo_wren_reg;
   assign rgb_mode        = rgb_mode_reg;
   assign column          = column_reg;
   assign row             = row_reg;
   assign frame_done      = frame_done_reg;
   assign frame_count     = frame_count_reg;

endmodule
